lfsr_stream_cipher: RTL and testbench

Parametrised successor to the byte-wide LFSR cipher core. Generalised LFSR width and taps, a configurable number of LFSR steps per character, and valid/ready handshakes on input and output. Adds a printable-table mode (mod-95 add/subtract over 0x20..0x7E) alongside plain XOR mode. Sits between the character source and sink in the encrypt and decrypt paths; the same block serves both directions.

---
 rtl/lfsr_stream_cipher_pkg.sv | 24 ++
 rtl/lfsr_stream_cipher_keygen.sv | 41 ++++
 rtl/lfsr_stream_cipher.sv | 111 +++++++++++
 tb/tb_lfsr_stream_cipher.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_stream_cipher_pkg.sv
// Shared constants and types for the LFSR stream cipher: printable-table bounds,
// FSM state encoding and the default 16-bit Galois tap mask.
package lfsr_cipher_pkg;

    localparam logic [7:0]  TABLE_LO       = 8'h20;
    localparam logic [7:0]  TABLE_HI       = 8'h7E;
    localparam logic [7:0]  TABLE_SIZE     = 8'd95;
    localparam logic [15:0] DEFAULT_TAPS16 = 16'hB400;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A byte is below 3*95, so two conditional subtractions give k mod 95.
    function automatic logic [6:0] mod95(input logic [7:0] k);
        logic [7:0] r;
        r = k;
        if (r >= TABLE_SIZE) r = r - TABLE_SIZE;
        if (r >= TABLE_SIZE) r = r - TABLE_SIZE;
        return r[6:0];
    endfunction

endpackage

// File: rtl/lfsr_stream_cipher_keygen.sv
// Galois right-shift LFSR keystream generator; STEP shifts are unrolled into
// one combinational advance so a whole key byte is produced per cycle.
module lfsr_keygen
    import lfsr_cipher_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = DEFAULT_TAPS16,
    parameter int                STEP   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    output logic [7:0]        key
);

    logic [LFSR_W-1:0] state;
    logic [LFSR_W-1:0] next_state;

    always_comb begin
        next_state = state;
        for (int i = 0; i < STEP; i++) begin
            next_state = (next_state >> 1) ^ (next_state[0] ? TAPS : '0);
        end
    end

    // An all-zero state would lock the register, so a zero seed becomes 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LFSR_W'(1);
        end else if (load) begin
            state <= (seed == '0) ? LFSR_W'(1) : seed;
        end else if (advance) begin
            state <= next_state;
        end
    end

    assign key = state[7:0];

endmodule

// File: rtl/lfsr_stream_cipher.sv
// Character stream cipher: XOR or printable-table (mod-95) transform keyed by an
// LFSR, with valid/ready on both sides and a one-cycle registered output.
module lfsr_stream_cipher
    import lfsr_cipher_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = DEFAULT_TAPS16,
    parameter int                STEP   = 1,
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              mode_dec,
    input  logic              table_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_in_table,
    output logic              busy,
    output logic [CNT_W-1:0]  char_count
);

    state_t     state;
    logic       dec_q;
    logic       tab_q;
    logic [7:0] key;
    logic       xfer;
    logic       advance;
    logic       in_tab;
    logic [6:0] idx;
    logic [6:0] r;
    logic [7:0] tab_idx;
    logic [7:0] res_data;
    logic       res_tab;

    // Handshake: a character moves on an edge where in_valid && in_ready. The
    // output register may take a new character only when it is empty or being
    // drained this cycle; out_valid/out_data hold until out_ready is seen.
    assign in_ready = (state == RUN) && !start && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready;
    assign busy     = (state == RUN);

    always_comb begin
        in_tab  = (in_data >= TABLE_LO) && (in_data <= TABLE_HI);
        idx     = 7'(in_data - TABLE_LO);
        r       = mod95(key);
        tab_idx = 8'd0;
        if (!dec_q) begin
            tab_idx = {1'b0, idx} + {1'b0, r};
            if (tab_idx >= TABLE_SIZE) tab_idx = tab_idx - TABLE_SIZE;
        end else if (idx >= r) begin
            tab_idx = {1'b0, idx} - {1'b0, r};
        end else begin
            tab_idx = {1'b0, idx} + TABLE_SIZE - {1'b0, r};
        end

        res_tab  = 1'b0;
        res_data = in_data ^ key;
        if (tab_q) begin
            res_tab  = in_tab;
            res_data = in_tab ? (tab_idx + TABLE_LO) : in_data;
        end
    end

    // Out-of-table characters leave the keystream untouched so both ends stay aligned.
    assign advance = xfer && (!tab_q || in_tab);

    lfsr_keygen #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .STEP   (STEP)
    ) u_keygen (
        .clk     (clk),
        .rst     (rst),
        .load    (start),
        .seed    (seed_in),
        .advance (advance),
        .key     (key)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            dec_q        <= 1'b0;
            tab_q        <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= 8'd0;
            out_in_table <= 1'b0;
            char_count   <= '0;
        end else if (start) begin
            state      <= RUN;
            dec_q      <= mode_dec;
            tab_q      <= table_mode;
            out_valid  <= 1'b0;
            char_count <= '0;
        end else if (xfer) begin
            out_valid    <= 1'b1;
            out_data     <= res_data;
            out_in_table <= res_tab;
            if (char_count != '1) char_count <= char_count + CNT_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Self-checking bench for lfsr_stream_cipher: directed cases plus randomized
// round trips against a mod-95 / XOR reference model with an expected queue.
module tb_lfsr_stream_cipher;

    localparam int          LFSR_W = 16;
    localparam logic [15:0] TAPS   = 16'hB400;
    localparam int          STEP   = 1;
    localparam int          CNT_W  = 16;

    typedef logic [7:0] bq_t[$];

    logic              clk;
    logic              rst;
    logic              start;
    logic [LFSR_W-1:0] seed_in;
    logic              mode_dec;
    logic              table_mode;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              out_in_table;
    logic              busy;
    logic [CNT_W-1:0]  char_count;

    lfsr_stream_cipher #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .STEP   (STEP),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .seed_in      (seed_in),
        .mode_dec     (mode_dec),
        .table_mode   (table_mode),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_in_table (out_in_table),
        .busy         (busy),
        .char_count   (char_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        logic [15:0] v;
        v = s;
        for (int i = 0; i < STEP; i++) v = v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
        return v;
    endfunction

    function automatic logic [8:0] model_char(input logic [7:0] c, input logic [7:0] k,
                                              input logic dec, input logic tab);
        int o;
        if (!tab) return {1'b0, c ^ k};
        if (c < 8'h20 || c > 8'h7E) return {1'b0, c};
        if (dec) o = (int'(c) - 32 - int'(k) % 95 + 95) % 95;
        else     o = (int'(c) - 32 + int'(k) % 95) % 95;
        return {1'b1, 8'(o + 32)};
    endfunction

    logic [15:0] m_lfsr = 16'd1;
    logic        m_dec  = 1'b0;
    logic        m_tab  = 1'b0;
    logic        m_run  = 1'b0;
    logic        m_ov   = 1'b0;
    logic [15:0] m_cnt  = 16'd0;
    logic [8:0]  exp_q[$];
    logic [8:0]  got_q[$];
    logic [8:0]  m_e;
    logic        m_rdy;

    // Scoreboard: values at the falling edge are those the next rising edge acts on.
    always @(negedge clk) begin
        if (rst) begin
            m_lfsr = 16'd1; m_dec = 1'b0; m_tab = 1'b0; m_run = 1'b0; m_ov = 1'b0; m_cnt = 16'd0;
            exp_q.delete();
        end else begin
            m_rdy = m_run && !start && (!m_ov || out_ready);
            check("in_ready", in_ready, m_rdy);
            check("out_valid", out_valid, m_ov);
            check("busy", busy, m_run);
            check("char_count", char_count, m_cnt);
            if (m_ov) begin
                if (exp_q.size() == 0) check("exp_q_empty", 1, 0);
                else begin
                    check("out_data", {out_in_table, out_data}, exp_q[0]);
                    if (out_ready) begin
                        got_q.push_back({out_in_table, out_data});
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (start) begin
                exp_q.delete();
                m_lfsr = (seed_in == 16'd0) ? 16'd1 : seed_in;
                m_dec = mode_dec; m_tab = table_mode; m_cnt = 16'd0; m_ov = 1'b0; m_run = 1'b1;
            end else if (m_rdy && in_valid) begin
                m_e = model_char(in_data, m_lfsr[7:0], m_dec, m_tab);
                exp_q.push_back(m_e);
                if (!m_tab || m_e[8]) m_lfsr = lfsr_adv(m_lfsr);
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                m_ov = 1'b1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
        end
    end

    // ---------------- driver tasks (entered just after a rising edge) ----------------
    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic do_start(input logic [15:0] seed, input logic dec, input logic tab);
        start = 1'b1; seed_in = seed; mode_dec = dec; table_mode = tab; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        got_q.delete();
    endtask

    task automatic send_str(input bq_t s, input logic bp);
        logic acc;
        int   n;
        for (int i = 0; i < s.size(); i++) begin
            in_valid = 1'b1;
            in_data  = s[i];
            n = 0;
            do begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                if (bp) out_ready = ($urandom_range(0, 3) != 0);
                n++;
            end while (!acc && n < 200);
            if (!acc) check("send_timeout", 1, 0);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (m_ov && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (m_ov) check("drain_timeout", 1, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_in_table"}, out_in_table, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_char_count"}, char_count, 0);
    endtask

    // ---------------- stimulus ----------------
    logic [8:0] save_q[$];
    bq_t        pt, ct;
    int         len;

    initial begin
        rst = 1'b1; start = 1'b0; seed_in = '0; mode_dec = 1'b0; table_mode = 1'b0;
        in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;

        // 1: reset, then a character offered in IDLE is ignored
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'h41;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("idle_count", char_count, 0);
        check("idle_out_valid", out_valid, 0);

        // 2: XOR encrypt/decrypt of "circuit"
        do_start(16'h0001, 1'b0, 1'b0);
        send_str(str2q("circuit"), 1'b0);
        drain();
        check("xor_ct_len", got_q.size(), 7);
        if (got_q.size() == 7) begin
            check("xor_ct0", got_q[0], 9'h062);
            check("xor_ct1", got_q[1], 9'h069);
            save_q = got_q;
            ct.delete();
            foreach (got_q[i]) ct.push_back(got_q[i][7:0]);
            do_start(16'h0001, 1'b1, 1'b0);
            send_str(ct, 1'b0);
            drain();
            pt = str2q("circuit");
            check("xor_pt_len", got_q.size(), 7);
            foreach (got_q[i]) check("xor_pt", got_q[i], {1'b0, pt[i]});
            check("xor_count7", char_count, 7);
        end

        // 3: table mode single characters and wrap
        do_start(16'h0001, 1'b0, 1'b1);
        send_str(str2q("c"), 1'b0); drain();
        check("tab_c", (got_q.size() == 1) ? got_q[0] : 9'h1FF, 9'h164);
        do_start(16'h0001, 1'b0, 1'b1);
        send_str(str2q("~"), 1'b0); drain();
        check("tab_wrap_enc", (got_q.size() == 1) ? got_q[0] : 9'h1FF, 9'h120);
        do_start(16'h0001, 1'b1, 1'b1);
        send_str(str2q(" "), 1'b0); drain();
        check("tab_wrap_dec", (got_q.size() == 1) ? got_q[0] : 9'h1FF, 9'h17E);

        // 4: out-of-table character does not disturb the keystream
        do_start(16'hACE1, 1'b0, 1'b1);
        send_str(str2q("ab\ncd"), 1'b0); drain();
        save_q = got_q;
        check("skip_count5", char_count, 5);
        do_start(16'hACE1, 1'b0, 1'b1);
        send_str(str2q("abcd"), 1'b0); drain();
        check("skip_count4", char_count, 4);
        if (save_q.size() == 5 && got_q.size() == 4) begin
            check("skip_a", save_q[0], got_q[0]);
            check("skip_b", save_q[1], got_q[1]);
            check("skip_nl", save_q[2], 9'h00A);
            check("skip_c", save_q[3], got_q[2]);
            check("skip_d", save_q[4], got_q[3]);
        end else check("skip_len", 0, 1);

        // 5: backpressure mid-stream matches an unstalled run
        pt = str2q("backpressure");
        do_start(16'h1D2C, 1'b0, 1'b0);
        send_str(pt, 1'b0); drain();
        save_q = got_q;
        do_start(16'h1D2C, 1'b0, 1'b0);
        send_str(pt[0:3], 1'b0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = pt[4];
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        send_str(pt[4:$], 1'b0); drain();
        check("bp_len", got_q.size(), save_q.size());
        if (got_q.size() == save_q.size())
            foreach (got_q[i]) check("bp_seq", got_q[i], save_q[i]);

        // 6: restart discards a pending output; zero seed acts as 1; mid-stream reset
        do_start(16'h0BAD, 1'b0, 1'b0);
        out_ready = 1'b0;
        send_str(str2q("U"), 1'b0);
        check("pend_valid", out_valid, 1);
        do_start(16'h0BAD, 1'b0, 1'b0);
        check("restart_drop", out_valid, 0);
        out_ready = 1'b1;
        send_str(str2q("U"), 1'b0); drain();
        check("restart_first", (got_q.size() == 1) ? got_q[0] : 9'h1FF, 9'h0F8);

        do_start(16'h0001, 1'b0, 1'b0);
        send_str(str2q("circuit"), 1'b0); drain();
        save_q = got_q;
        do_start(16'h0000, 1'b0, 1'b0);
        send_str(str2q("circuit"), 1'b0); drain();
        check("zero_seed_len", got_q.size(), save_q.size());
        if (got_q.size() == save_q.size())
            foreach (got_q[i]) check("zero_seed", got_q[i], save_q[i]);

        do_start(16'h5A5A, 1'b0, 1'b1);
        send_str(str2q("mid"), 1'b0);
        in_valid = 1'b1; in_data = 8'h41; start = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("midrst");
        rst = 1'b0;

        // randomized round trips with random backpressure
        for (int run = 0; run < 8; run++) begin
            logic [15:0] sd;
            logic        tb_tab;
            sd     = 16'($urandom_range(0, 16'hFFFF));
            tb_tab = 1'($urandom_range(0, 1));
            len    = $urandom_range(10, 30);
            pt.delete();
            for (int i = 0; i < len; i++)
                pt.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                         : 8'($urandom_range(32, 126)));
            do_start(sd, 1'b0, tb_tab);
            send_str(pt, 1'b1); drain();
            check("rnd_ct_len", got_q.size(), len);
            ct.delete();
            foreach (got_q[i]) begin
                ct.push_back(got_q[i][7:0]);
                if (got_q[i][8]) check("rnd_in_range",
                                       (got_q[i][7:0] >= 8'h20 && got_q[i][7:0] <= 8'h7E), 1);
            end
            do_start(sd, 1'b1, tb_tab);
            send_str(ct, 1'b1); drain();
            check("rnd_pt_len", got_q.size(), len);
            if (got_q.size() == len)
                foreach (got_q[i]) check("rnd_roundtrip", got_q[i][7:0], pt[i]);
            check("rnd_count", char_count, len);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
